// File: rtl/instr_sequencer_if.sv
// Instruction-source and data-memory handshake bundle seen by the sequencer.
// The master side is the instruction source and memory; the slave side is the sequencer.
interface instr_sequencer_if;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ack;

    modport master (
        output instruction, instr_valid, mem_ack,
        input  instr_ready, mem_re, mem_we
    );

    modport slave (
        input  instruction, instr_valid, mem_ack,
        output instr_ready, mem_re, mem_we
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM that fetches 16-bit instructions and drives datapath strobes.
// state     | meaning
// FETCH     | ready for an instruction, latch it into IR on valid
// DECODE    | classify IR: ALU op, memory op, halt or illegal
// EXECUTE   | ALU operation, flag update for ADD/SUB/CMP
// MEM       | hold read/write request until mem_ack or timeout
// WRITEBACK | write ALU result or load data to Rdest
// HALT      | stopped until reset
module instr_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    instr_sequencer_if.slave bus,
    output logic             ir_load,
    output logic [3:0]       rdest,
    output logic [3:0]       rsrc,
    output logic [3:0]       alu_op,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             flag_we,
    output logic             instr_done,
    output logic             illegal,
    output logic             timeout,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_TIMEOUT - 1);

    function automatic logic is_alu(input logic [15:0] ir);
        return (ir[15:12] == 4'h0) &&
               (ir[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD});
    endfunction

    function automatic logic is_load(input logic [15:0] ir);
        return (ir[15:12] == 4'h4) && (ir[7:4] == 4'h0);
    endfunction

    function automatic logic is_stor(input logic [15:0] ir);
        return (ir[15:12] == 4'h4) && (ir[7:4] == 4'h4);
    endfunction

    function automatic logic is_cmp(input logic [15:0] ir);
        return (ir[15:12] == 4'h0) && (ir[7:4] == 4'hB);
    endfunction

    function automatic logic sets_flags(input logic [15:0] ir);
        return (ir[15:12] == 4'h0) && (ir[7:4] inside {4'h5, 4'h9, 4'hB});
    endfunction

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  wait_q, wait_d;
    logic        ready_q, ready_d;
    logic        reg_we_q, reg_we_d;
    logic        wb_sel_q, wb_sel_d;
    logic        flag_we_q, flag_we_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        halted_q, halted_d;
    logic        stor_done_evt;
    logic        timeout_evt;

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        wait_d        = wait_q;
        stor_done_evt = 1'b0;
        timeout_evt   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_q == 16'h0000) begin
                    state_d = S_HALT;
                end else if (is_alu(ir_q)) begin
                    state_d = S_EXECUTE;
                end else if (is_load(ir_q) || is_stor(ir_q)) begin
                    state_d = S_MEM;
                    wait_d  = WAIT_INIT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: state_d = is_cmp(ir_q) ? S_FETCH : S_WRITEBACK;
            S_MEM: begin
                // An ack on the last allowed cycle still completes the access.
                if (bus.mem_ack) begin
                    state_d       = is_load(ir_q) ? S_WRITEBACK : S_FETCH;
                    stor_done_evt = is_stor(ir_q);
                end else if (wait_q == 4'd0) begin
                    state_d     = S_FETCH;
                    timeout_evt = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        ready_d   = (state_d == S_FETCH);
        illegal_d = (state_d == S_DECODE) && (ir_d != 16'h0000) && !is_alu(ir_d) &&
                    !is_load(ir_d) && !is_stor(ir_d);
        flag_we_d = (state_d == S_EXECUTE) && sets_flags(ir_d);
        reg_we_d  = (state_d == S_WRITEBACK);
        wb_sel_d  = (state_d == S_WRITEBACK) && is_load(ir_d);
        mem_re_d  = (state_d == S_MEM) && is_load(ir_d);
        mem_we_d  = (state_d == S_MEM) && is_stor(ir_d);
        done_d    = (state_d == S_WRITEBACK) || ((state_d == S_EXECUTE) && is_cmp(ir_d)) ||
                    stor_done_evt;
        timeout_d = timeout_evt;
        halted_d  = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ir_q      <= 16'h0000;
            wait_q    <= 4'd0;
            ready_q   <= 1'b1;
            reg_we_q  <= 1'b0;
            wb_sel_q  <= 1'b0;
            flag_we_q <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            ready_q   <= ready_d;
            reg_we_q  <= reg_we_d;
            wb_sel_q  <= wb_sel_d;
            flag_we_q <= flag_we_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            halted_q  <= halted_d;
        end
    end

    assign ir_load         = (state_q == S_FETCH) && bus.instr_valid;
    assign bus.instr_ready = ready_q;
    assign bus.mem_re      = mem_re_q;
    assign bus.mem_we      = mem_we_q;
    assign rdest           = ir_q[11:8];
    assign rsrc            = ir_q[3:0];
    assign alu_op          = ir_q[7:4];
    assign reg_we          = reg_we_q;
    assign wb_sel          = wb_sel_q;
    assign flag_we         = flag_we_q;
    assign instr_done      = done_q;
    assign illegal         = illegal_q;
    assign timeout         = timeout_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle strobe traces against hand-derived tables.
module tb_instr_sequencer;
    logic       clk;
    logic       rst;
    logic       ir_load;
    logic [3:0] rdest, rsrc, alu_op;
    logic       reg_we, wb_sel, flag_we, instr_done, illegal, timeout, halted;

    int checks   = 0;
    int failures = 0;

    instr_sequencer_if bus();

    instr_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ir_load(ir_load),
        .rdest(rdest), .rsrc(rsrc), .alu_op(alu_op),
        .reg_we(reg_we), .wb_sel(wb_sel), .flag_we(flag_we),
        .instr_done(instr_done), .illegal(illegal), .timeout(timeout), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe mask bits: reg_we, wb_sel, flag_we, mem_re, mem_we, instr_done, illegal, timeout
    logic [7:0] tr_s   [64];
    logic       tr_ld  [64];
    logic       tr_rdy [64];
    logic [3:0] tr_rd  [64];
    logic [3:0] tr_rs  [64];
    logic [3:0] tr_aop [64];

    function automatic logic [7:0] smask();
        return {reg_we, wb_sel, flag_we, bus.mem_re, bus.mem_we, instr_done, illegal, timeout};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Presents w for one cycle from FETCH and records n cycles; mem_ack pulses on cycle ack_at.
    task automatic capture(input logic [15:0] w, input int n, input int ack_at);
        for (int i = 0; i < n; i++) begin
            bus.instruction = w;
            bus.instr_valid = (i == 0);
            bus.mem_ack     = (i == ack_at);
            #1;
            tr_s[i]   = smask();
            tr_ld[i]  = ir_load;
            tr_rdy[i] = bus.instr_ready;
            tr_rd[i]  = rdest;
            tr_rs[i]  = rsrc;
            tr_aop[i] = alu_op;
            next_cycle();
        end
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.instruction = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({smask(), halted, ir_load, rdest, rsrc, alu_op} !== 22'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {smask(), halted, ir_load, rdest, rsrc, alu_op});
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        next_cycle();
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", bus.instr_ready);
        end
    endtask

    task automatic test_stor();
        logic [7:0] exp_s [4] = '{8'h00, 8'h00, 8'h08, 8'h04};
        capture(16'h4142, 4, 2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tr_s[i] !== exp_s[i] || tr_ld[i] !== (i == 0)) begin
                failures++;
                $display("FAIL stor_cycle%0d strobes=%h ld=%b exp=%h ld=%b",
                         i, tr_s[i], tr_ld[i], exp_s[i], (i == 0));
            end
        end
        checks++;
        if (tr_rd[1] !== 4'd1 || tr_rs[1] !== 4'd2) begin
            failures++;
            $display("FAIL stor_fields rdest=%0d rsrc=%0d exp=1,2", tr_rd[1], tr_rs[1]);
        end
    endtask

    task automatic test_load();
        logic [7:0] exp_s [7] = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'hC4, 8'h00};
        capture(16'h4402, 7, 4);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (tr_s[i] !== exp_s[i]) begin
                failures++;
                $display("FAIL load_cycle%0d strobes=%h exp=%h", i, tr_s[i], exp_s[i]);
            end
        end
        checks++;
        if (tr_rd[5] !== 4'd4 || tr_rdy[6] !== 1'b1) begin
            failures++;
            $display("FAIL load_wb rdest=%0d ready=%b exp=4,1", tr_rd[5], tr_rdy[6]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog    [3] = '{16'h0253, 16'h0291, 16'h05D2};
        logic [3:0]  exp_aop [3] = '{4'h5, 4'h9, 4'hD};
        logic [3:0]  exp_rd  [3] = '{4'h2, 4'h2, 4'h5};
        logic [3:0]  exp_rs  [3] = '{4'h3, 4'h1, 4'h2};
        logic [7:0]  exp_ex  [3] = '{8'h20, 8'h20, 8'h00};
        logic [7:0]  exp_s;
        for (int i = 0; i < 13; i++) begin
            bus.instruction = prog[(i < 12) ? i / 4 : 2];
            bus.instr_valid = (i < 12);
            #1;
            tr_s[i]   = smask();
            tr_ld[i]  = ir_load;
            tr_aop[i] = alu_op;
            tr_rd[i]  = rdest;
            tr_rs[i]  = rsrc;
            next_cycle();
        end
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            exp_s = 8'h00;
            if (i < 12 && i % 4 == 2) exp_s = exp_ex[i / 4];
            if (i < 12 && i % 4 == 3) exp_s = 8'h84;
            checks++;
            if (tr_s[i] !== exp_s || tr_ld[i] !== (i < 12 && i % 4 == 0)) begin
                failures++;
                $display("FAIL b2b_cycle%0d strobes=%h ld=%b exp=%h ld=%b",
                         i, tr_s[i], tr_ld[i], exp_s, (i < 12 && i % 4 == 0));
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tr_aop[4*k+1] !== exp_aop[k] || tr_rd[4*k+1] !== exp_rd[k] ||
                tr_rs[4*k+1] !== exp_rs[k]) begin
                failures++;
                $display("FAIL b2b_fields%0d aop=%h rd=%h rs=%h exp=%h %h %h", k,
                         tr_aop[4*k+1], tr_rd[4*k+1], tr_rs[4*k+1],
                         exp_aop[k], exp_rd[k], exp_rs[k]);
            end
        end
    endtask

    task automatic test_cmp();
        logic [7:0] exp_s [4] = '{8'h00, 8'h00, 8'h24, 8'h00};
        capture(16'h01B3, 4, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tr_s[i] !== exp_s[i]) begin
                failures++;
                $display("FAIL cmp_cycle%0d strobes=%h exp=%h", i, tr_s[i], exp_s[i]);
            end
        end
        checks++;
        if (tr_rdy[3] !== 1'b1 || tr_aop[2] !== 4'hB) begin
            failures++;
            $display("FAIL cmp_retire ready=%b aop=%h exp=1,b", tr_rdy[3], tr_aop[2]);
        end
    endtask

    task automatic test_illegal_halt();
        logic [7:0] exp_s [3] = '{8'h00, 8'h02, 8'h00};
        int seen_ld;
        capture(16'h7123, 3, -1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tr_s[i] !== exp_s[i]) begin
                failures++;
                $display("FAIL illegal_cycle%0d strobes=%h exp=%h", i, tr_s[i], exp_s[i]);
            end
        end
        checks++;
        if (tr_rdy[2] !== 1'b1) begin
            failures++;
            $display("FAIL illegal_ready got=%b exp=1", tr_rdy[2]);
        end
        capture(16'h0000, 3, -1);
        checks++;
        if (tr_s[1] !== 8'h00 || tr_s[2] !== 8'h00 || tr_rdy[2] !== 1'b0) begin
            failures++;
            $display("FAIL halt_entry strobes=%h ready=%b exp=00,0", tr_s[2], tr_rdy[2]);
        end
        seen_ld = 0;
        bus.instruction = 16'h0253;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ir_load !== 1'b0 || halted !== 1'b1 || bus.instr_ready !== 1'b0) seen_ld++;
            next_cycle();
        end
        bus.instr_valid = 1'b0;
        checks++;
        if (seen_ld !== 0) begin
            failures++;
            $display("FAIL halt_hold bad_cycles=%0d exp=0", seen_ld);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL halt_async_reset halted=%b ready=%b exp=0,1", halted, bus.instr_ready);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_timeout();
        int bad;
        logic [7:0] exp_s;
        capture(16'h4142, 19, -1);
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            exp_s = (i >= 2 && i <= 16) ? 8'h08 : ((i == 17) ? 8'h01 : 8'h00);
            if (tr_s[i] !== exp_s) begin
                bad++;
                $display("FAIL timeout_cycle%0d strobes=%h exp=%h", i, tr_s[i], exp_s);
            end
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (tr_rdy[17] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_ready got=%b exp=1", tr_rdy[17]);
        end
    endtask

    task automatic test_reset_mid_mem();
        int bad;
        bus.instruction = 16'h4402;
        bus.instr_valid = 1'b1;
        next_cycle();
        bus.instr_valid = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (bus.mem_re !== 1'b1) begin
            failures++;
            $display("FAIL midmem_pre mem_re=%b exp=1", bus.mem_re);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_re !== 1'b0 || bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL midmem_reset mem_re=%b ready=%b exp=0,1", bus.mem_re, bus.instr_ready);
        end
        next_cycle();
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (reg_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.instr_ready !== 1'b1) bad++;
            next_cycle();
        end
        bus.mem_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midmem_after bad_cycles=%0d exp=0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_stor();
        test_load();
        test_back_to_back();
        test_cmp();
        test_illegal_halt();
        test_timeout();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM between the instruction source and the datapath (register file, ALU, flag register, data memory) inside top.
- Accepts one 16-bit instruction per handshake, decodes it and drives datapath strobes over FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Encoding: [15:12] opcode, [11:8] Rdest, [7:4] opext, [3:0] Rsrc/Raddr.
- Instruction 16'h0000 halts the machine.

Parameters:
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ack before aborting (4-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
instruction  in  16  instruction word from source
instr_valid  in  1  instruction word valid
instr_ready  out  1  sequencer can accept an instruction this cycle
mem_ack  in  1  data memory completed requested access
ir_load  out  1  latch instruction into IR (one-cycle pulse)
rdest  out  4  registered Rdest field of IR
rsrc  out  4  registered Rsrc/Raddr field of IR
alu_op  out  4  ALU function (opext of IR; 4'hD for MOV)
reg_we  out  1  register file write enable
wb_sel  out  1  write-back source: 0 ALU result, 1 memory read data
flag_we  out  1  flag register (C,L,F,Z,N) write enable
mem_re  out  1  data memory read request
mem_we  out  1  data memory write request (data = R[Rdest], addr = R[Rsrc])
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse when an undecodable instruction is discarded
timeout  out  1  one-cycle pulse when a memory access aborts
halted  out  1  high while in HALT

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH; IR=0; all strobes and pulses 0; halted=0; rdest=rsrc=alu_op=0. Reset mid-instruction abandons it with no write strobes; instr_ready=1 on the first cycle after release.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH:
  - instr_ready=1.
  - On instr_valid=1: ir_load=1 that cycle, IR<=instruction, next DECODE.
  - Otherwise hold in FETCH.
- DECODE (instr_ready=0):
  - IR==16'h0000 -> HALT.
  - opcode 0000 with opext in {0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1011 CMP, 1101 MOV} -> EXECUTE.
  - opcode 0100 with opext 0000 (LOAD) or 0100 (STOR) -> MEM.
  - Any other encoding -> illegal pulse, no strobes, -> FETCH.
- EXECUTE:
  - alu_op valid.
  - ADD/SUB/CMP: flag_we=1.
  - CMP -> FETCH with instr_done=1; no reg_we.
  - Others -> WRITEBACK.
- WRITEBACK: reg_we=1, wb_sel=0 (or 1 for LOAD), instr_done=1, -> FETCH.
- MEM:
  - LOAD holds mem_re=1; STOR holds mem_we=1, until mem_ack=1.
  - On ack: LOAD -> WRITEBACK; STOR -> FETCH with instr_done=1.
  - mem_ack sampled only in MEM; ack in other states is ignored.
  - Wait counter clears on MEM entry. If ack is absent for MEM_TIMEOUT cycles: timeout pulse, strobes drop, -> FETCH, no writeback.
- HALT: halted=1, instr_ready=0. Only reset exits.
- Latency, valid to next ready with zero-wait memory:
  - R-type: 4 cycles.
  - CMP, STOR: 3 cycles.
  - LOAD: 4 cycles + memory wait states.
  - Illegal: 2 cycles.
- Every strobe is Moore-decoded from state+IR. reg_we, mem_we and flag_we are never high in the same cycle, except that no combination is permitted at all. ir_load appears only in FETCH.
- rdest/rsrc/alu_op are stable from DECODE through retirement.

Test Plan:
- Reset, then 16'h4142 (STOR R1->M[R2]) with mem_ack returned on the first MEM cycle -> mem_we high exactly 1 cycle, rdest=1, rsrc=2, instr_done 3 cycles after ir_load, no reg_we.
- 16'h4402 (LOAD R4) with mem_ack delayed 2 cycles -> mem_re high 3 cycles, then reg_we=1 with wb_sel=1 and rdest=4, instr_done once.
- Sequence 16'h0253, 16'h0291, 16'h05D2 (ADD, SUB, MOV) with instr_valid held high:
  - ir_load every 4 cycles; alu_op=5, 9, D.
  - flag_we only for ADD and SUB; reg_we on the 4th cycle of each.
- 16'h01B3 (CMP) -> flag_we=1 in EXECUTE, reg_we never asserted, instr_done at cycle 3.
- 16'h7123 (illegal) -> illegal pulse in DECODE, no strobes, back in FETCH. Then 16'h0000 -> halted=1, instr_ready=0 indefinitely despite instr_valid; rst=0 returns state to FETCH asynchronously.
- STOR with mem_ack never asserted -> timeout pulse after 15 MEM cycles, mem_we drops, no instr_done. Separately, assert rst=0 mid-MEM of a LOAD -> mem_re drops immediately, no reg_we afterwards.
